mul_acc_collect: RTL and testbench
==================================

// Module: mul_acc_collect
// PURPOSE
//  Downstream stage of the 8x8 pipelined multiplier. Takes its 16-bit product stream
//  (product + enable strobe), sums every LEN consecutive valid products into one
//  ACC_W-bit dot-product result, and queues results in a small FIFO. The FIFO drives
//  a valid/ready output. The multiplier cannot be stalled, so this block never
//  back-pressures its input; a result that finds the FIFO full is dropped and flagged.
// PARAMETERS
//  IN_W       16  product width, equal to 2*multiplier operand size
//  ACC_W      24  accumulator / result width; ACC_W >= IN_W
//  LEN        4   products per result, 1..255
//  FIFO_DEPTH 2   result FIFO entries, power of 2, >= 2
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  prod_en    in   1        product strobe (multiplier enable-out)
//  prod_data  in   IN_W     product, sampled when prod_en=1
//  clear      in   1        sync abort of partial sum; clears overrun
//  acc_valid  out  1        FIFO head valid
//  acc_ready  in   1        consumer accepts head when acc_valid & acc_ready
//  acc_data   out  ACC_W    FIFO head result
//  acc_sat    out  1        FIFO head result saturated (0 without ACC_SAT_EN)
//  acc_cnt    out  8        products accumulated so far in current result
//  overrun    out  1        sticky: a completed result was dropped
// BEHAVIOUR
//  - Reset (async, any time incl. mid-accumulation): all outputs 0, partial sum and
//    count 0, FIFO emptied, FSM to IDLE. No partial result survives reset.
//  - FSM: IDLE (cnt=0) -> ACCUM on prod_en. ACCUM stays while cnt<LEN.
//    ACCUM -> IDLE when the LEN-th product arrives. In that cycle
//    acc+zero_ext(prod_data) is pushed to the FIFO and cnt returns to 0.
//  - LEN=1: every strobe pushes a result directly from IDLE.
//  - Gaps between strobes are allowed; the partial sum holds while prod_en=0.
//  - Latency: acc_valid rises 1 cycle after the clock edge sampling the LEN-th
//    product, if the FIFO was empty.
//  - FIFO: push and pop happen at the same edge. Pop on acc_valid&acc_ready.
//    Full + pop + push in the same cycle is legal: occupancy is unchanged and order
//    is preserved. Full with no pop: the new result is discarded and overrun<=1.
//    acc_data/acc_sat hold stable while acc_valid=1 and acc_ready=0.
//  - clear: partial sum and cnt go to 0, FSM to IDLE, overrun goes to 0. FIFO
//    contents are kept. clear wins over a simultaneous prod_en; that product is
//    discarded.
//  - Arithmetic: unsigned. Without ACC_SAT_EN the sum wraps modulo 2^ACC_W.
// CONFIGURATION
//  ACC_SAT_EN defined: each add clamps to {ACC_W{1'b1}} on carry-out. The clamped
//    value is sticky for the rest of that result, and the result's acc_sat=1.
//  ACC_SAT_EN undefined: wrap-around arithmetic; acc_sat tied 0 and no sat bit is
//    stored in the FIFO.
// STRUCTURE
//  - mul_acc_pkg: FSM state enum (IDLE, ACCUM) and the default width localparams.
//  - Sub-module acc_result_fifo: registered sync FIFO of {sat,data} words with
//    push/pop/full/empty. It is the only instance.
//  - Top holds the FSM, counter, accumulator and overrun flag.
// TESTING (defaults unless stated)
//  1 Assert rst_n=0 mid-accumulation after 2 products -> all outputs 0; then 4
//    products of 1 -> result 4, not 4+stale.
//  2 Back-to-back products 15,20,25,30 -> acc_data=90, acc_valid=1 one cycle after
//    30; acc_cnt steps 1,2,3 then 0.
//  3 Same four products with 1-3 idle cycles between strobes -> acc_data=90; acc_cnt
//    holds during gaps.
//  4 acc_ready=0, three results (90, 4, 8) -> FIFO holds 90,4; 8 dropped; overrun=1;
//    then acc_ready=1 pops 90 then 4.
//  5 After 2 products, clear=1 with prod_en=1 -> that product ignored, acc_cnt=0,
//    overrun=0; next 4 products of 2 -> 8.
//  6 ACC_W=16, four products 0xFE01 -> ACC_SAT_EN: acc_data=0xFFFF with acc_sat=1;
//    without the macro: acc_data=0xF804 with acc_sat=0.

Source files
------------

// File: rtl/mul_acc_pkg.sv
// Shared types and default widths for the product-stream accumulator.
package mul_acc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int IN_W_DEF       = 16;
    localparam int ACC_W_DEF      = 24;
    localparam int LEN_DEF        = 4;
    localparam int FIFO_DEPTH_DEF = 2;
    localparam int CNT_W          = 8;

endpackage

// File: rtl/acc_result_fifo.sv
// Registered synchronous FIFO holding completed results.
// A push while full is accepted only when a pop frees the slot at the same edge.
module acc_result_fifo
    import mul_acc_pkg::*;
#(
    parameter int WIDTH = ACC_W_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_acc_collect.sv
// Sums every LEN product strobes into one result and queues it for a valid/ready consumer.
// Define ACC_SAT_EN for per-result saturating accumulation with a stored sat flag.
module mul_acc_collect
    import mul_acc_pkg::*;
#(
    parameter int IN_W       = IN_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int LEN        = LEN_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             prod_en,
    input  logic [IN_W-1:0]  prod_data,
    input  logic             clear,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_data,
    output logic             acc_sat,
    output logic [CNT_W-1:0] acc_cnt,
    output logic             overrun
);

`ifdef ACC_SAT_EN
    localparam int FW = ACC_W + 1;
`else
    localparam int FW = ACC_W;
`endif

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nx;
    logic [ACC_W-1:0] sum;
    logic [FW-1:0]    wdata;
    logic [FW-1:0]    rdata;
    logic             take;
    logic             last;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign take = prod_en & ~clear;
    assign last = (cnt == CNT_W'(LEN - 1));

`ifdef ACC_SAT_EN
    localparam int SW = ACC_W + 1;

    logic [ACC_W:0] wide;
    logic           sat_r;
    logic           sat_nx;
    logic           sat_sum;

    // Once a carry is seen the result stays pinned at all-ones.
    assign wide    = SW'(acc) + SW'(prod_data);
    assign sat_sum = sat_r | wide[ACC_W];
    assign sum     = sat_sum ? '1 : wide[ACC_W-1:0];
    assign wdata   = {sat_sum, sum};
    assign acc_sat = rdata[ACC_W];

    always_comb begin
        sat_nx = sat_r;
        if (clear || (take && last)) begin
            sat_nx = 1'b0;
        end else if (take) begin
            sat_nx = sat_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_r <= 1'b0;
        end else begin
            sat_r <= sat_nx;
        end
    end
`else
    assign sum     = acc + ACC_W'(prod_data);
    assign wdata   = sum;
    assign acc_sat = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        acc_nx   = acc;
        push     = 1'b0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    acc_nx   = sum;
                    cnt_nx   = CNT_W'(1);
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (take) begin
                    acc_nx = sum;
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (take && last) begin
            push     = 1'b1;
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = IDLE;
        end
        if (clear) begin
            acc_nx   = '0;
            cnt_nx   = '0;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            acc   <= acc_nx;
            if (clear) begin
                overrun <= 1'b0;
            end else if (push && full && !pop) begin
                overrun <= 1'b1;
            end
        end
    end

    assign acc_valid = ~empty;
    assign pop       = acc_valid & acc_ready;
    assign acc_data  = rdata[ACC_W-1:0];
    assign acc_cnt   = cnt;

    acc_result_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mul_acc_collect.sv
// Randomized and directed bench for mul_acc_collect against a queue-based model.
module tb_mul_acc_collect;

    localparam int  W     = 24;
    localparam int  LEN   = 4;
    localparam int  DEPTH = 2;
    localparam longint MAXV = (64'd1 << W) - 1;
`ifdef ACC_SAT_EN
    localparam bit  SAT   = 1'b1;
`else
    localparam bit  SAT   = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          prod_en;
    logic [15:0]   prod_data;
    logic          clear;
    logic          acc_valid;
    logic          acc_ready;
    logic [W-1:0]  acc_data;
    logic          acc_sat;
    logic [7:0]    acc_cnt;
    logic          overrun;

    logic          p16_en;
    logic [15:0]   p16_data;
    logic          v16;
    logic [15:0]   d16;
    logic          s16;
    logic [7:0]    c16;
    logic          o16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_acc_collect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_en   (prod_en),
        .prod_data (prod_data),
        .clear     (clear),
        .acc_valid (acc_valid),
        .acc_ready (acc_ready),
        .acc_data  (acc_data),
        .acc_sat   (acc_sat),
        .acc_cnt   (acc_cnt),
        .overrun   (overrun)
    );

    mul_acc_collect #(.ACC_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .prod_en   (p16_en),
        .prod_data (p16_data),
        .clear     (1'b0),
        .acc_valid (v16),
        .acc_ready (1'b0),
        .acc_data  (d16),
        .acc_sat   (s16),
        .acc_cnt   (c16),
        .overrun   (o16)
    );

    // Model: running sum, product count and the ordered list of queued results.
    longint        m_sum;
    int            m_cnt;
    bit            m_sat;
    bit            m_over;
    logic [W:0]    q[$];
    bit            m_pop;
    bit            m_have;
    logic [W:0]    m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sum  = 0;
            m_cnt  = 0;
            m_sat  = 0;
            m_over = 0;
            q.delete();
        end else begin
            m_pop  = (q.size() > 0) && acc_ready;
            m_have = 0;
            if (clear) begin
                m_sum  = 0;
                m_cnt  = 0;
                m_sat  = 0;
                m_over = 0;
            end else if (prod_en) begin
                m_sum = m_sum + longint'(prod_data);
                if (m_sum > MAXV) begin
                    if (SAT) m_sat = 1;
                    else m_sum = m_sum - (MAXV + 1);
                end
                if (m_sat) m_sum = MAXV;
                m_cnt++;
                if (m_cnt == LEN) begin
                    m_have = 1;
                    m_res  = {m_sat, W'(m_sum)};
                    m_sum  = 0;
                    m_cnt  = 0;
                    m_sat  = 0;
                end
            end
            if (m_pop) void'(q.pop_front());
            if (m_have) begin
                if (q.size() < DEPTH) q.push_back(m_res);
                else m_over = 1;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("cmp_valid", longint'(acc_valid), longint'(q.size() > 0));
        if (q.size() > 0) begin
            chk("cmp_data", longint'(acc_data), longint'(q[0][W-1:0]));
            chk("cmp_sat", longint'(acc_sat), longint'(q[0][W]));
        end
        chk("cmp_cnt", longint'(acc_cnt), longint'(m_cnt));
        chk("cmp_overrun", longint'(overrun), longint'(m_over));
    end

    task automatic drive(input bit en, input logic [15:0] d,
                         input bit clr, input bit rdy);
        prod_en   = en;
        prod_data = d;
        clear     = clr;
        acc_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input bit en, input logic [15:0] d);
        p16_en   = en;
        p16_data = d;
        drive(0, 0, 0, 0);
        p16_en   = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_valid"}, longint'(acc_valid), 0);
        chk({name, "_data"}, longint'(acc_data), 0);
        chk({name, "_sat"}, longint'(acc_sat), 0);
        chk({name, "_cnt"}, longint'(acc_cnt), 0);
        chk({name, "_overrun"}, longint'(overrun), 0);
    endtask

    initial begin
        logic [15:0] t3 [4];
        t3 = '{16'd15, 16'd20, 16'd25, 16'd30};
        rst_n = 0;
        prod_en = 0;
        prod_data = 0;
        clear = 0;
        acc_ready = 0;
        p16_en = 0;
        p16_data = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        // Reset in the middle of a result.
        drive(1, 16'd7, 0, 0);
        drive(1, 16'd7, 0, 0);
        chk("t1_cnt2", longint'(acc_cnt), 2);
        #2 rst_n = 0;
        #1 chk_zero("t1_async");
        @(posedge clk);
        #1 rst_n = 1;
        repeat (4) drive(1, 16'd1, 0, 1);
        chk("t1_valid", longint'(acc_valid), 1);
        chk("t1_data", longint'(acc_data), 4);
        drive(0, 0, 0, 1);
        chk("t1_popped", longint'(acc_valid), 0);

        // Back-to-back products.
        for (int i = 0; i < 4; i++) begin
            drive(1, t3[i], 0, 0);
            chk("t2_cnt", longint'(acc_cnt), (i + 1) % 4);
        end
        chk("t2_valid", longint'(acc_valid), 1);
        chk("t2_data", longint'(acc_data), 90);
        drive(0, 0, 0, 1);

        // Idle gaps between strobes.
        for (int i = 0; i < 4; i++) begin
            drive(1, t3[i], 0, 0);
            repeat ($urandom_range(1, 3)) begin
                drive(0, 16'hdead, 0, 0);
                chk("t3_hold", longint'(acc_cnt), (i + 1) % 4);
            end
        end
        chk("t3_data", longint'(acc_data), 90);
        drive(0, 0, 0, 1);

        // Full FIFO drops the third result.
        for (int i = 0; i < 4; i++) drive(1, t3[i], 0, 0);
        repeat (4) drive(1, 16'd1, 0, 0);
        chk("t4_ovr_pre", longint'(overrun), 0);
        repeat (4) drive(1, 16'd2, 0, 0);
        chk("t4_overrun", longint'(overrun), 1);
        chk("t4_head", longint'(acc_data), 90);
        repeat (3) drive(0, 0, 0, 0);
        chk("t4_stable", longint'(acc_data), 90);
        drive(0, 0, 0, 1);
        chk("t4_second", longint'(acc_data), 4);
        drive(0, 0, 0, 1);
        chk("t4_empty", longint'(acc_valid), 0);

        // Clear beats a simultaneous strobe.
        drive(1, 16'd3, 0, 0);
        drive(1, 16'd3, 0, 0);
        drive(1, 16'd5, 1, 0);
        chk("t5_cnt", longint'(acc_cnt), 0);
        chk("t5_overrun", longint'(overrun), 0);
        repeat (4) drive(1, 16'd2, 0, 1);
        chk("t5_data", longint'(acc_data), 8);
        drive(0, 0, 0, 1);

        // 16-bit accumulator overflow.
        repeat (4) drive16(1, 16'hfe01);
        chk("t6_valid", longint'(v16), 1);
        chk("t6_data", longint'(d16), SAT ? 64'hffff : 64'hf804);
        chk("t6_sat", longint'(s16), longint'(SAT));

        // Random traffic, first with a slow consumer then a fast one.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom),
                  $urandom_range(0, 39) == 0,
                  (i < 300) ? ($urandom_range(0, 3) == 0)
                            : ($urandom_range(0, 1) == 1));
        end
        repeat (4) drive(0, 0, 0, 1);
        chk("end_empty", longint'(acc_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
